sram_mem_ctrl: RTL and testbench
================================

# sram_mem_ctrl

Memory-stage controller placed between the EX/MEM pipeline register and an external 16-bit asynchronous SRAM; it replaces the single-cycle word array as the MEM-stage data store. It accepts one 32-bit load/store per pipeline slot and splits it into two half-word SRAM accesses with fixed wait states. It returns the assembled load word and drives `ready`, whose inverse freezes the pipeline while an access is in flight.

## Interface
- `ACCESS_CYCLES`, default 2: clock cycles each half-word access is held on the SRAM pins; legal range 1–15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memRead` in 1: load request from EX/MEM.
- `memWrite` in 1: store request from EX/MEM.
- `address` in 32: byte address of the access.
- `data` in 32: store data.
- `memOut` out 32: load result.
- `ready` out 1: access complete, or no access requested; pipeline freeze = `~ready`.
- `sramAddr` out 18: SRAM half-word address.
- `sramWrData` out 16: SRAM write data.
- `sramRdData` in 16: SRAM read data; valid while `sramWeN`=1.
- `sramWeN` out 1: SRAM write enable, active low.

## Operation
- Address mapping:
  - `offs = address - BASE_ADDR`, computed at 32 bits with silent wrap; there is no range check.
  - `idx = offs[18:2]` (17 bits).
  - Low half-word address = `{idx,1'b0}`; high half-word address = `{idx,1'b1}`.
- State machine: IDLE, LOW, HIGH, DONE, plus a 4-bit wait counter `cnt`.
- IDLE:
  - If `memRead|memWrite`: latch `address`, `data`, and the operation (write wins if both are high); load `cnt=ACCESS_CYCLES-1`; go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - Drive `sramAddr={idx,0}`.
  - Write: `sramWrData=data[15:0]` and `sramWeN=0`.
  - Read: `sramWeN=1`.
  - Decrement `cnt`. When `cnt==0`: a read captures `sramRdData` into `rbuf[15:0]`; reload `cnt`; go to HIGH.
- HIGH: same as LOW using `{idx,1}`, `data[31:16]`, and `rbuf[31:16]`; then go to DONE.
- DONE: lasts one cycle, then always returns to IDLE. The pipeline advances on this edge.
- `ready` (combinational) = `(state==DONE) | (state==IDLE & ~memRead & ~memWrite)`.
- `memOut` = `rbuf` when `state==DONE` and the latched operation is a read; 0 otherwise.
- Outside LOW/HIGH writes, `sramWeN=1`. `sramAddr` and `sramWrData` hold their last value.
- Read and write both high: performs a write only; `memOut`=0 in DONE.

## Timing
- Reset values:
  - State IDLE, `cnt` 0, `rbuf` 0, latches 0.
  - `sramWeN` 1, `sramAddr` 0, `sramWrData` 0, `memOut` 0.
  - `ready` follows its combinational rule.
- Latency: request first seen in IDLE at cycle 0 → LOW for cycles 1..A → HIGH for cycles A+1..2A → DONE at cycle 2A+1. With A=2, `ready` goes high in cycle 5.
- `sramWeN` low is glitch-free and registered. Each half-word sees exactly A cycles of stable address, data, and `sramWeN`.
- Back-to-back requests: after DONE, the next request is sampled in IDLE. There is one IDLE cycle between accesses, with `ready`=0 in that cycle.
- Request inputs are ignored outside IDLE; the latched copies are used.
- `rst` mid-access:
  - Aborts the access: next state is IDLE and `sramWeN`=1 on the following cycle.
  - A partially written word is not repaired.

## Configuration
- `SRAM_LASTWORD_EN` defined:
  - Adds a one-entry buffer: valid bit, 17-bit `idx`, 32-bit word; valid is cleared on `rst`.
  - Any completed read or write loads the buffer (write-through).
  - A read whose `idx` matches a valid entry goes IDLE→DONE directly, with `ready` in cycle 1 and `memOut` = the buffered word. No SRAM cycles are issued.
  - Writes always go to the SRAM.
- Undefined: no buffer; every access takes 2A+2 cycles including IDLE.

## Test plan
- Reset: assert `rst` 2 cycles with no request → `ready`=1, `memOut`=0, `sramWeN`=1, `sramAddr`=0.
- Store: `address`=1028, `data`=0xDEADBEEF, A=2 →
  - `sramAddr`=2 with `sramWrData`=0xBEEF and `sramWeN`=0 for cycles 1–2.
  - `sramAddr`=3 with 0xDEAD for cycles 3–4.
  - `ready`=1 only in cycle 5.
- Load the same address from the SRAM model → `memOut`=0xDEADBEEF exactly in the DONE cycle, 0 before and after.
- Simultaneous `memRead` and `memWrite` at `address`=1024, `data`=0x12345678 → SRAM words 0/1 = 0x5678/0x1234; `memOut`=0.
- `rst` asserted in cycle 3 of a store → cycle 4: IDLE, `sramWeN`=1; a following load completes normally.
- With `SRAM_LASTWORD_EN`: load 1028 twice → the second load has `ready` in cycle 1, `memOut`=0xDEADBEEF, and `sramWeN` never changes. Without the macro → both loads take 5 cycles.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two half-word accesses on a 16-bit async SRAM.
// Optional one-entry last-word read buffer is enabled by defining SRAM_LASTWORD_EN.
module sram_mem_ctrl #(
  parameter int ACCESS_CYCLES = 2,
  parameter int BASE_ADDR     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] memOut,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramWrData,
  input  logic [15:0] sramRdData,
  output logic        sramWeN
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] offs;
  logic [16:0] idx_in;
  logic [16:0] idx_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic [31:0] rbuf;
  logic        req;
  logic        last_beat;
  logic        hit;
  logic [31:0] hit_word;
  logic        unused_offs;

  // Address window wraps silently; only the half-word index bits matter.
  assign offs        = address - 32'(BASE_ADDR);
  assign idx_in      = offs[18:2];
  assign unused_offs = ^{offs[31:19], offs[1:0]};
  assign req         = memRead | memWrite;
  assign last_beat   = (cnt == 4'd0);

`ifdef SRAM_LASTWORD_EN
  logic        lw_valid;
  logic [16:0] lw_idx;
  logic [31:0] lw_word;

  assign hit      = memRead & ~memWrite & lw_valid & (lw_idx == idx_in);
  assign hit_word = lw_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      lw_valid <= 1'b0;
      lw_idx   <= '0;
      lw_word  <= '0;
    end else if (state == HIGH && last_beat) begin
      lw_valid <= 1'b1;
      lw_idx   <= idx_q;
      lw_word  <= wr_q ? data_q : {sramRdData, rbuf[15:0]};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = hit ? DONE : LOW;
      LOW:  if (last_beat) state_nxt = HIGH;
      HIGH: if (last_beat) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins are registered and set up on the edge entering each phase,
  // so every half-word sees ACCESS_CYCLES cycles of stable pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      cnt        <= '0;
      rbuf       <= '0;
      sramAddr   <= '0;
      sramWrData <= '0;
      sramWeN    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q  <= idx_in;
            data_q <= data;
            wr_q   <= memWrite;
            cnt    <= CNT_RELOAD;
            if (hit) begin
              rbuf <= hit_word;
            end else begin
              sramAddr <= {idx_in, 1'b0};
              sramWeN  <= ~memWrite;
              if (memWrite) sramWrData <= data[15:0];
            end
          end
        end
        LOW: begin
          if (last_beat) begin
            cnt      <= CNT_RELOAD;
            sramAddr <= {idx_q, 1'b1};
            if (wr_q) sramWrData <= data_q[31:16];
            else      rbuf[15:0] <= sramRdData;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HIGH: begin
          if (last_beat) begin
            cnt     <= CNT_RELOAD;
            sramWeN <= 1'b1;
            if (!wr_q) rbuf[31:16] <= sramRdData;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready  = (state == DONE) | ((state == IDLE) & ~memRead & ~memWrite);
  assign memOut = (state == DONE && !wr_q) ? rbuf : 32'd0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl (ACCESS_CYCLES=2) with a 64-word behavioural SRAM.
// Latency expectations adapt when SRAM_LASTWORD_EN is defined.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [31:0] address, data;
  logic [31:0] memOut;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramWrData;
  logic [15:0] sramRdData;
  logic        sramWeN;

  logic [15:0] sram [0:63];
  int checks = 0;
  int errors = 0;

`ifdef SRAM_LASTWORD_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 5;
`endif

  sram_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .data       (data),
    .memOut     (memOut),
    .ready      (ready),
    .sramAddr   (sramAddr),
    .sramWrData (sramWrData),
    .sramRdData (sramRdData),
    .sramWeN    (sramWeN)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!sramWeN) sram[sramAddr[5:0]] <= sramWrData;
  assign sramRdData = sram[sramAddr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; cycle 0 is the current cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdat, input int lat, input logic [31:0] exp_out);
    logic [31:0] o;
    logic [17:0] lo;
    o  = addr - 32'd1024;
    lo = {o[18:2], 1'b0};
    memRead = rd; memWrite = wr; address = addr; data = wdat;
    #1;
    check("ready_c0", 32'(ready), 32'd0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check("ready", 32'(ready), (c == lat) ? 32'd1 : 32'd0);
      check("memOut", memOut, (c == lat) ? exp_out : 32'd0);
      if (c < lat) begin
        check("sramAddr", 32'(sramAddr), (c <= 2) ? 32'(lo) : 32'(lo | 18'd1));
        check("sramWeN", 32'(sramWeN), wr ? 32'd0 : 32'd1);
        if (wr) check("sramWrData", 32'(sramWrData), (c <= 2) ? 32'(wdat[15:0]) : 32'(wdat[31:16]));
      end else begin
        check("sramWeN_idle", 32'(sramWeN), 32'd1);
      end
    end
    memRead = 1'b0; memWrite = 1'b0;
    #1;
    check("ready_idle", 32'(ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 16'h0000;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_memOut", memOut, 32'd0);
    check("rst_sramWeN", 32'(sramWeN), 32'd1);
    check("rst_sramAddr", 32'(sramAddr), 32'd0);
    check("rst_sramWrData", 32'(sramWrData), 32'd0);
    rst = 1'b0;

    // store then load of the same word
    run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5, 32'd0);
    check("sram_w2", 32'(sram[2]), 32'h0000BEEF);
    check("sram_w3", 32'(sram[3]), 32'h0000DEAD);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, HIT_LAT, 32'hDEADBEEF);

    // read and write together: write wins, no load data
    run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 5, 32'd0);
    check("sram_w0", 32'(sram[0]), 32'h00005678);
    check("sram_w1", 32'(sram[1]), 32'h00001234);

    // reset during the high half of a store
    memWrite = 1'b1; address = 32'd1036; data = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_c1_addr", 32'(sramAddr), 32'd6);
    @(negedge clk);
    check("abort_c2_wd", 32'(sramWrData), 32'h0000F00D);
    @(negedge clk);
    check("abort_c3_addr", 32'(sramAddr), 32'd7);
    check("abort_c3_wen", 32'(sramWeN), 32'd0);
    rst = 1'b1; memWrite = 1'b0;
    @(negedge clk);
    check("abort_c4_wen", 32'(sramWeN), 32'd1);
    check("abort_c4_ready", 32'(ready), 32'd1);
    check("abort_c4_memOut", memOut, 32'd0);
    rst = 1'b0;
    check("sram_w6", 32'(sram[6]), 32'h0000F00D);
    run_access(1'b1, 1'b0, 32'd1036, 32'h0, 5, 32'hCAFEF00D);

    // two loads of 1028: the second can hit the last-word buffer
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 5, 32'hDEADBEEF);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, HIT_LAT, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
